// File: rtl/axis_keep_packer_if.sv
// Stream bundle around the keep packer: the sparse input stream (s_*)
// and the dense output stream (m_*). The packer uses the slave view; the
// environment feeding it and draining it uses the master view.
interface axis_keep_packer_if #(
  parameter int S_BYTES = 4,
  parameter int M_BYTES = 8,
  parameter int CNT_W   = 32
) ();
  logic                   s_valid;
  logic                   s_ready;
  logic [S_BYTES*8-1:0]   s_data;
  logic [S_BYTES-1:0]     s_keep;
  logic                   s_last;

  logic                   m_valid;
  logic                   m_ready;
  logic [M_BYTES*8-1:0]   m_data;
  logic [M_BYTES-1:0]     m_keep;
  logic                   m_last;
  logic [CNT_W-1:0]       m_pkt_bytes;

  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last, m_pkt_bytes
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last, m_pkt_bytes
  );
endinterface

// File: rtl/axis_keep_packer.sv
// Compacts the kept bytes of a sparse AXI-Stream into dense M_BYTES beats.
// Bytes collect in a small buffer; a beat goes out once a full word is
// available or the packet's last input beat has been taken. Input is only
// accepted while the output side is idle, so a presented beat never changes
// underneath a stalled consumer.
module axis_keep_packer #(
  parameter int S_BYTES = 4,
  parameter int M_BYTES = 8,
  parameter int CNT_W   = 32
) (
  input logic               aclk,
  input logic               areset,
  axis_keep_packer_if.slave axis
);

  localparam int D     = M_BYTES + S_BYTES;
  localparam int OCC_W = $clog2(D + 1);
  localparam logic [OCC_W-1:0] M_OCC = OCC_W'(M_BYTES);

  logic [7:0]       byte_q [D];
  logic [7:0]       byte_n [D];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_n;
  logic             last_pend_q;
  logic             last_pend_n;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_n;
  logic             rst_hold_q;

  logic [OCC_W-1:0] emit_n;
  logic             s_ready_w;
  logic             m_valid_w;
  logic             m_last_w;
  logic             accept;
  logic             emit;
  int               pos;

  // Number of bytes the current output beat carries.
  assign emit_n = (occ_q > M_OCC) ? M_OCC : occ_q;

  // The input is held off for one cycle after reset and whenever a beat is
  // (or is about to be) presented, which keeps the output contents frozen.
  assign s_ready_w = !areset && !rst_hold_q && !last_pend_q && (occ_q < M_OCC);
  assign m_valid_w = !areset && ((occ_q >= M_OCC) || last_pend_q);
  assign m_last_w  = !areset && last_pend_q && (occ_q <= M_OCC);

  assign accept = axis.s_valid && s_ready_w;
  assign emit   = m_valid_w && axis.m_ready;

  assign axis.s_ready     = s_ready_w;
  assign axis.m_valid     = m_valid_w;
  assign axis.m_last      = m_last_w;
  assign axis.m_pkt_bytes = m_last_w ? (pkt_cnt_q + CNT_W'(emit_n)) : '0;

  // Present the low buffer bytes; lanes beyond the beat's byte count read 0.
  always_comb begin
    axis.m_data = '0;
    axis.m_keep = '0;
    for (int i = 0; i < M_BYTES; i++) begin
      if (!areset && (OCC_W'(i) < emit_n)) begin
        axis.m_data[8*i +: 8] = byte_q[i];
        axis.m_keep[i]        = 1'b1;
      end
    end
  end

  // Next buffer state: shift out the emitted beat first, then append the
  // kept lanes of an accepted beat in ascending lane order.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      byte_n[i] = byte_q[i];
    end
    occ_n       = occ_q;
    last_pend_n = last_pend_q;
    pkt_cnt_n   = pkt_cnt_q;
    pos         = 0;

    if (emit) begin
      for (int j = 0; j < D; j++) begin
        if (j + int'(emit_n) < D) begin
          byte_n[j] = byte_q[j + int'(emit_n)];
        end else begin
          byte_n[j] = 8'h00;
        end
      end
      occ_n     = occ_q - emit_n;
      pkt_cnt_n = pkt_cnt_q + CNT_W'(emit_n);
      if (m_last_w) begin
        occ_n       = '0;
        last_pend_n = 1'b0;
        pkt_cnt_n   = '0;
      end
    end

    if (accept) begin
      pos = int'(occ_n);
      for (int i = 0; i < S_BYTES; i++) begin
        if (axis.s_keep[i]) begin
          if (pos < D) begin
            byte_n[pos] = axis.s_data[8*i +: 8];
          end
          pos = pos + 1;
        end
      end
      occ_n = OCC_W'(pos);
      if (axis.s_last) begin
        last_pend_n = 1'b1;
      end
    end
  end

  // Register the packer state; reset drops any partially collected packet.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < D; i++) begin
        byte_q[i] <= 8'h00;
      end
      occ_q       <= '0;
      last_pend_q <= 1'b0;
      pkt_cnt_q   <= '0;
      rst_hold_q  <= 1'b1;
    end else begin
      for (int i = 0; i < D; i++) begin
        byte_q[i] <= byte_n[i];
      end
      occ_q       <= occ_n;
      last_pend_q <= last_pend_n;
      pkt_cnt_q   <= pkt_cnt_n;
      rst_hold_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_keep_packer.sv
// Bench for the keep packer: a reference model turns every accepted input
// beat into the dense beats it should produce, and a monitor pops and
// compares them as the DUT hands them off.
module tb_axis_keep_packer;

  localparam int S_BYTES = 4;
  localparam int M_BYTES = 8;
  localparam int CNT_W   = 32;

  typedef struct packed {
    logic [M_BYTES*8-1:0] data;
    logic [M_BYTES-1:0]   keep;
    logic                 last;
    logic [CNT_W-1:0]     pkt;
  } beat_t;

  logic aclk = 1'b0;
  logic areset;

  axis_keep_packer_if #(.S_BYTES(S_BYTES), .M_BYTES(M_BYTES), .CNT_W(CNT_W)) bus ();

  axis_keep_packer #(.S_BYTES(S_BYTES), .M_BYTES(M_BYTES), .CNT_W(CNT_W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus)
  );

  // Free-running clock.
  always #5 aclk = ~aclk;

  int compare_count  = 0;
  int mismatch_count = 0;
  int valid_pct      = 100;
  int ready_pct      = 100;
  int last_seen      = 0;
  int model_cnt      = 0;
  beat_t      exp_q[$];
  logic [7:0] model_pend[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void modelEmit(input int n, input logic last);
    beat_t b;
    b = '0;
    for (int j = 0; j < n; j++) begin
      b.data[8*j +: 8] = model_pend.pop_front();
      b.keep[j]        = 1'b1;
    end
    model_cnt = model_cnt + n;
    b.last    = last;
    b.pkt     = last ? CNT_W'(model_cnt) : '0;
    if (last) model_cnt = 0;
    exp_q.push_back(b);
  endfunction

  function automatic void modelAccept(input logic [S_BYTES*8-1:0] data,
                                      input logic [S_BYTES-1:0] keep, input logic last);
    for (int i = 0; i < S_BYTES; i++) begin
      if (keep[i]) model_pend.push_back(data[8*i +: 8]);
    end
    if (last) begin
      while (model_pend.size() > M_BYTES) modelEmit(M_BYTES, 1'b0);
      modelEmit(model_pend.size(), 1'b1);
    end else begin
      while (model_pend.size() >= M_BYTES) modelEmit(M_BYTES, 1'b0);
    end
  endfunction

  // Drives one input beat (called at a falling edge) and records its effect.
  task automatic applyStimulus(input logic [S_BYTES*8-1:0] data,
                               input logic [S_BYTES-1:0] keep, input logic last);
    int wait_cycles;
    while ($urandom_range(0, 99) >= valid_pct) @(negedge aclk);
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_keep  = keep;
    bus.s_last  = last;
    wait_cycles = 0;
    while (!bus.s_ready && wait_cycles < 5000) begin
      @(negedge aclk);
      wait_cycles++;
    end
    if (!bus.s_ready) checkOutput("accept timeout", 64'd0, 64'd1);
    else modelAccept(data, keep, last);
    @(negedge aclk);
    bus.s_valid = 1'b0;
    bus.s_keep  = '0;
    bus.s_last  = 1'b0;
  endtask

  task automatic sendPacket(input int n, input logic [7:0] seed);
    int idx;
    int rem;
    logic [S_BYTES*8-1:0] data;
    logic [S_BYTES-1:0]   keep;
    idx = 0;
    while (idx < n) begin
      rem  = n - idx;
      data = '0;
      keep = '0;
      for (int i = 0; i < S_BYTES; i++) begin
        if (i < rem) begin
          data[8*i +: 8] = seed + 8'(idx + i);
          keep[i]        = 1'b1;
        end
      end
      applyStimulus(data, keep, rem <= S_BYTES);
      idx = idx + S_BYTES;
    end
  endtask

  task automatic waitDrain();
    int cycles;
    cycles = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && cycles < 20000) begin
      @(negedge aclk);
      cycles++;
    end
    checkOutput("leftover beats", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer readiness changes just after each rising edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      bus.m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Output monitor: scoreboard compare on handshakes, stability while stalled.
  initial begin
    beat_t exp_b;
    logic  hold_valid;
    logic [M_BYTES*8-1:0] held_data;
    logic [M_BYTES-1:0]   held_keep;
    logic                 held_last;
    logic [CNT_W-1:0]     held_pkt;
    hold_valid = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid) begin
          checkOutput("hold valid", 64'(bus.m_valid), 64'd1);
          checkOutput("hold data", 64'(bus.m_data), 64'(held_data));
          checkOutput("hold keep", 64'(bus.m_keep), 64'(held_keep));
          checkOutput("hold last", 64'(bus.m_last), 64'(held_last));
          checkOutput("hold pkt_bytes", 64'(bus.m_pkt_bytes), 64'(held_pkt));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected beat", 64'd1, 64'd0);
          end else begin
            exp_b = exp_q.pop_front();
            checkOutput("beat data", 64'(bus.m_data), 64'(exp_b.data));
            checkOutput("beat keep", 64'(bus.m_keep), 64'(exp_b.keep));
            checkOutput("beat last", 64'(bus.m_last), 64'(exp_b.last));
            checkOutput("beat pkt_bytes", 64'(bus.m_pkt_bytes), 64'(exp_b.pkt));
          end
          if (bus.m_last) last_seen++;
        end
        hold_valid = bus.m_valid && !bus.m_ready;
        held_data  = bus.m_data;
        held_keep  = bus.m_keep;
        held_last  = bus.m_last;
        held_pkt   = bus.m_pkt_bytes;
      end
    end
  end

  // Hang guard.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  // Test sequence.
  initial begin
    int last_before;
    areset      = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_keep  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("reset s_ready", 64'(bus.s_ready), 64'd0);
    checkOutput("reset m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("reset m_last", 64'(bus.m_last), 64'd0);
    checkOutput("reset m_keep", 64'(bus.m_keep), 64'd0);
    checkOutput("reset m_pkt_bytes", 64'(bus.m_pkt_bytes), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // Dense 20-byte packet.
    sendPacket(20, 8'h00);
    waitDrain();

    // Sparse keep across two beats.
    applyStimulus(32'hA3A2A1A0, 4'b1010, 1'b0);
    applyStimulus(32'hB3B2B1B0, 4'b0101, 1'b1);
    waitDrain();

    // Full word followed by an empty last beat.
    applyStimulus(32'h03020100, 4'hF, 1'b0);
    applyStimulus(32'h07060504, 4'hF, 1'b0);
    applyStimulus(32'h00000000, 4'h0, 1'b1);
    waitDrain();

    // Long packet under random starvation and backpressure.
    last_before = last_seen;
    valid_pct   = 20;
    ready_pct   = 20;
    sendPacket(1000, 8'h37);
    waitDrain();
    checkOutput("single m_last", 64'(last_seen - last_before), 64'd1);
    valid_pct = 100;
    ready_pct = 100;
    repeat (2) @(negedge aclk);

    // Back-to-back short packets.
    last_before = last_seen;
    sendPacket(5, 8'h50);
    sendPacket(3, 8'h60);
    waitDrain();
    checkOutput("two m_last", 64'(last_seen - last_before), 64'd2);

    // Reset with six bytes buffered mid-packet.
    applyStimulus(32'h13121110, 4'hF, 1'b0);
    applyStimulus(32'h17161514, 4'b0011, 1'b0);
    areset = 1'b1;
    #1;
    checkOutput("in reset s_ready", 64'(bus.s_ready), 64'd0);
    checkOutput("in reset m_valid", 64'(bus.m_valid), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    model_pend.delete();
    model_cnt = 0;
    checkOutput("post reset m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("post reset s_ready", 64'(bus.s_ready), 64'd0);
    @(negedge aclk);
    checkOutput("recovered s_ready", 64'(bus.s_ready), 64'd1);
    sendPacket(8, 8'h80);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
